hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage RV32I core. Sits beside the operand-forwarding logic.
- Covers the hazards forwarding cannot resolve:
  - load-use stalls, including branch/JALR resolved in ID that consume a load result
  - taken-branch flush
  - instruction-fetch wait
  - full-pipeline freeze while data memory is busy
- Drives stall/flush (bubble) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Keeps a stall-cycle performance counter and a sticky memory-timeout flag.

Parameters:
NB_OPERAND, 5, register index width
MEM_TIMEOUT, 64, consecutive freeze cycles before timeout flag sets (>=2)
NB_PERF, 16, width of saturating stall-cycle counter

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_if_id_rs1 / i_if_id_rs2  in  NB_OPERAND  source regs of instruction in ID
i_if_id_use_rs1 / i_if_id_use_rs2  in  1  instruction in ID reads rs1/rs2
i_if_id_is_branch  in  1  ID instruction is branch/JALR (operands needed in ID)
i_branch_taken  in  1  ID resolved a taken branch/jump
i_id_ex_rd  in  NB_OPERAND  destination reg in EX
i_id_ex_mem_read  in  1  EX instruction is a load
i_ex_mem_rd  in  NB_OPERAND  destination reg in MEM
i_ex_mem_mem_read  in  1  MEM instruction is a load
i_imem_ready  in  1  instruction memory returns valid data this cycle
i_dmem_req  in  1  MEM stage access active
i_dmem_ready  in  1  data memory completes access this cycle
o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall, o_mem_wb_stall  out  1  hold stage register
o_if_id_flush, o_id_ex_flush  out  1  load bubble (NOP) into stage register
o_stalled  out  1  FSM in STALL
o_stall_cycles  out  NB_PERF  saturating count of cycles with o_pc_stall=1
o_mem_timeout  out  1  sticky: freeze lasted MEM_TIMEOUT cycles

Behaviour:
- Reset (async, i_rst_n=0): FSM=RUN, stall_cnt=0, freeze_cnt=0, o_stall_cycles=0, o_mem_timeout=0. All stall/flush outputs 0 while in reset. Reset mid-stall or mid-freeze aborts immediately; nothing is resumed.
- match_ex = i_id_ex_mem_read && i_id_ex_rd!=0 && ((use_rs1 && rd==rs1) || (use_rs2 && rd==rs2)). match_mem is the same using the ex_mem signals.
- Stall demand in RUN:
  - match_ex && !is_branch -> 1 cycle.
  - match_ex && is_branch -> 2 cycles.
  - match_mem && is_branch -> 1 cycle.
  - Otherwise 0.
- Stall cycle outputs: o_pc_stall=1, o_if_id_stall=1, o_id_ex_flush=1, o_stalled reflects FSM.
- FSM:
  - RUN: demand>0 -> assert stall outputs combinationally in the same cycle.
    - demand=2 -> go to STALL with stall_cnt=1.
    - demand=1 -> stay in RUN; the next cycle re-evaluates.
  - STALL: assert stall outputs and decrement stall_cnt. Return to RUN when stall_cnt reaches 0. Hazard inputs are ignored in STALL.
- Freeze = i_dmem_req && !i_dmem_ready. Freeze overrides everything:
  - All five *_stall outputs = 1; both flushes = 0.
  - FSM state and stall_cnt hold; i_branch_taken is ignored.
  - freeze_cnt increments, saturating at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, o_mem_timeout is set and stays set until reset.
  - freeze_cnt clears on any non-freeze cycle.
- Branch flush: only in RUN with demand=0 and no freeze. i_branch_taken=1 -> o_if_id_flush=1, o_pc_stall=0 (PC loads target), even if i_imem_ready=0. A taken branch during a stall cycle is ignored; the ID operands are not valid then.
- Fetch wait: no freeze, no stall, no taken branch, i_imem_ready=0 -> o_pc_stall=1, o_if_id_flush=1.
- Priority: reset > freeze > data-hazard stall > branch flush > fetch wait.
- o_stall_cycles increments on every cycle with o_pc_stall=1 (including freeze and fetch wait) and saturates at all-ones. Branch-flush cycles do not count.
- All outputs except counters and o_mem_timeout are combinational from FSM state and inputs (zero latency). State updates on the rising edge.

Test Plan:
- Load x5 in EX, ID ADD uses rs1=x5, non-branch -> exactly 1 cycle: pc_stall=1, if_id_stall=1, id_ex_flush=1. Next cycle, with EX now ALU, no stall. o_stall_cycles=1.
- Load x7 in EX, ID BEQ rs2=x7 -> 2 consecutive stall cycles (o_stalled=1 in the 2nd). Return to RUN in cycle 3. o_stall_cycles=2.
- Load x0 in EX, ID uses x0 -> no stall. ID has use_rs1=0 with rs1 matching -> no stall.
- RUN, i_branch_taken=1, i_imem_ready=0 -> if_id_flush=1, pc_stall=0. Same input during a load-use stall -> flush=0, stall outputs=1.
- In the 2nd stall of the branch-load case, hold dmem_req=1 / dmem_ready=0 for 5 cycles:
  - Stall outputs all 1, flushes 0, o_stalled held.
  - After ready, the remaining stall completes.
  - o_stall_cycles=7.
- With MEM_TIMEOUT=4, freeze 4 cycles -> o_mem_timeout=1 after the 4th edge and stays 1 after ready. Assert i_rst_n=0 mid-freeze -> all outputs 0, flag cleared, FSM=RUN.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Hazard-controller bundle: the pipeline's hazard-relevant inputs and the
// stall/flush controls returned to the pipeline stage registers.
interface hazard_controller_if #(
    parameter int NB_OPERAND = 5,
    parameter int NB_PERF    = 16
);
    logic [NB_OPERAND-1:0] i_if_id_rs1;
    logic [NB_OPERAND-1:0] i_if_id_rs2;
    logic                  i_if_id_use_rs1;
    logic                  i_if_id_use_rs2;
    logic                  i_if_id_is_branch;
    logic                  i_branch_taken;
    logic [NB_OPERAND-1:0] i_id_ex_rd;
    logic                  i_id_ex_mem_read;
    logic [NB_OPERAND-1:0] i_ex_mem_rd;
    logic                  i_ex_mem_mem_read;
    logic                  i_imem_ready;
    logic                  i_dmem_req;
    logic                  i_dmem_ready;

    logic                  o_pc_stall;
    logic                  o_if_id_stall;
    logic                  o_id_ex_stall;
    logic                  o_ex_mem_stall;
    logic                  o_mem_wb_stall;
    logic                  o_if_id_flush;
    logic                  o_id_ex_flush;
    logic                  o_stalled;
    logic [NB_PERF-1:0]    o_stall_cycles;
    logic                  o_mem_timeout;

    // Pipeline side: drives hazard information, receives controls.
    modport master (
        output i_if_id_rs1, i_if_id_rs2, i_if_id_use_rs1, i_if_id_use_rs2,
               i_if_id_is_branch, i_branch_taken, i_id_ex_rd, i_id_ex_mem_read,
               i_ex_mem_rd, i_ex_mem_mem_read, i_imem_ready, i_dmem_req, i_dmem_ready,
        input  o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall, o_mem_wb_stall,
               o_if_id_flush, o_id_ex_flush, o_stalled, o_stall_cycles, o_mem_timeout
    );

    // Controller side.
    modport slave (
        input  i_if_id_rs1, i_if_id_rs2, i_if_id_use_rs1, i_if_id_use_rs2,
               i_if_id_is_branch, i_branch_taken, i_id_ex_rd, i_id_ex_mem_read,
               i_ex_mem_rd, i_ex_mem_mem_read, i_imem_ready, i_dmem_req, i_dmem_ready,
        output o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall, o_mem_wb_stall,
               o_if_id_flush, o_id_ex_flush, o_stalled, o_stall_cycles, o_mem_timeout
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard sequencer for the 5-stage RV32I pipeline: load-use stalls (including
// branches resolved in ID), taken-branch flush, fetch wait and data-memory
// freeze, plus a saturating stall-cycle counter and a sticky timeout flag.
module hazard_controller #(
    parameter int NB_OPERAND  = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int NB_PERF     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    hazard_controller_if.slave bus
);

    localparam int NB_FREEZE = $clog2(MEM_TIMEOUT + 1);
    localparam logic [NB_FREEZE-1:0] FREEZE_MAX  = NB_FREEZE'(MEM_TIMEOUT);
    localparam logic [NB_FREEZE-1:0] FREEZE_LAST = NB_FREEZE'(MEM_TIMEOUT - 1);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            stall_cnt;
    logic [1:0]            stall_cnt_next;

    logic [NB_OPERAND-1:0] id_rs1;
    logic [NB_OPERAND-1:0] id_rs2;
    logic [NB_OPERAND-1:0] ex_rd;
    logic [NB_OPERAND-1:0] mem_rd;
    logic                  match_ex;
    logic                  match_mem;
    logic [1:0]            demand;
    logic                  freeze;
    logic                  hazard_stall;

    logic [NB_FREEZE-1:0]  freeze_cnt;
    logic [NB_PERF-1:0]    stall_cycles;
    logic                  mem_timeout;

    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  id_ex_stall;
    logic                  ex_mem_stall;
    logic                  mem_wb_stall;
    logic                  if_id_flush;
    logic                  id_ex_flush;

    assign id_rs1 = bus.i_if_id_rs1;
    assign id_rs2 = bus.i_if_id_rs2;
    assign ex_rd  = bus.i_id_ex_rd;
    assign mem_rd = bus.i_ex_mem_rd;

    // Load-use detection against the loads in EX and MEM; x0 never creates a hazard.
    always_comb begin
        match_ex  = bus.i_id_ex_mem_read && (ex_rd != '0) &&
                    ((bus.i_if_id_use_rs1 && (ex_rd == id_rs1)) ||
                     (bus.i_if_id_use_rs2 && (ex_rd == id_rs2)));
        match_mem = bus.i_ex_mem_mem_read && (mem_rd != '0) &&
                    ((bus.i_if_id_use_rs1 && (mem_rd == id_rs1)) ||
                     (bus.i_if_id_use_rs2 && (mem_rd == id_rs2)));
        demand = 2'd0;
        if (match_ex && bus.i_if_id_is_branch)       demand = 2'd2;
        else if (match_ex)                           demand = 2'd1;
        else if (match_mem && bus.i_if_id_is_branch) demand = 2'd1;
        freeze       = bus.i_dmem_req && !bus.i_dmem_ready;
        // Hazard inputs only count in RUN; in STALL the FSM itself holds the stall.
        hazard_stall = (state == STALL) || ((state == RUN) && (demand != 2'd0));
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= RUN;
            stall_cnt <= 2'd0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
        end
    end

    // FSM next state: a freeze holds everything; a 2-cycle demand parks one extra cycle in STALL.
    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        if (!freeze) begin
            case (state)
                RUN: begin
                    if (demand == 2'd2) begin
                        state_next     = STALL;
                        stall_cnt_next = 2'd1;
                    end
                end
                STALL: begin
                    stall_cnt_next = stall_cnt - 2'd1;
                    if (stall_cnt_next == 2'd0) state_next = RUN;
                end
                default: begin
                    state_next     = RUN;
                    stall_cnt_next = 2'd0;
                end
            endcase
        end
    end

    // FSM outputs by priority: freeze > data-hazard stall > branch flush > fetch wait.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else if (hazard_stall) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (bus.i_branch_taken) begin
            // PC loads the branch target; the wrong-path fetch is discarded.
            if_id_flush = 1'b1;
        end else if (!bus.i_imem_ready) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end
    end

    // Freeze watchdog and saturating stall-cycle counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            freeze_cnt   <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (freeze) begin
                if (freeze_cnt != FREEZE_MAX) freeze_cnt <= freeze_cnt + 1'b1;
                if (freeze_cnt >= FREEZE_LAST) mem_timeout <= 1'b1;
            end else begin
                freeze_cnt <= '0;
            end
            if (pc_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // Controls are forced inactive while reset is asserted.
    assign bus.o_pc_stall     = i_rst_n & pc_stall;
    assign bus.o_if_id_stall  = i_rst_n & if_id_stall;
    assign bus.o_id_ex_stall  = i_rst_n & id_ex_stall;
    assign bus.o_ex_mem_stall = i_rst_n & ex_mem_stall;
    assign bus.o_mem_wb_stall = i_rst_n & mem_wb_stall;
    assign bus.o_if_id_flush  = i_rst_n & if_id_flush;
    assign bus.o_id_ex_flush  = i_rst_n & id_ex_flush;
    assign bus.o_stalled      = i_rst_n & (state == STALL);
    assign bus.o_stall_cycles = stall_cycles;
    assign bus.o_mem_timeout  = mem_timeout;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed vectors push their
// hand-computed expected outputs; a monitor pops and compares each cycle.
module tb_hazard_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hazard_controller_if #(.NB_OPERAND(5), .NB_PERF(16)) bus ();

    hazard_controller #(
        .NB_OPERAND (5),
        .MEM_TIMEOUT(4),
        .NB_PERF    (16)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       isbr;
        logic       bt;
        logic [4:0] exrd;
        logic       exld;
        logic [4:0] memrd;
        logic       memld;
        logic       imem;
        logic       dreq;
        logic       drdy;
    } in_t;

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        idex;
        logic        exmem;
        logic        memwb;
        logic        ifid_fl;
        logic        idex_fl;
        logic        stalled;
        logic [15:0] cyc;
        logic        tmo;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    function automatic in_t nop();
        in_t v;
        v = '0;
        v.imem = 1'b1;
        return v;
    endfunction

    function automatic exp_t mk(input logic pc, ifid, idex, exmem, memwb, ififl, idexfl,
                                stalled, input int cyc, input logic tmo);
        exp_t e;
        e.pc = pc; e.ifid = ifid; e.idex = idex; e.exmem = exmem; e.memwb = memwb;
        e.ifid_fl = ififl; e.idex_fl = idexfl; e.stalled = stalled;
        e.cyc = 16'(cyc); e.tmo = tmo;
        return e;
    endfunction

    function automatic exp_t e_idle(input logic stalled, input int cyc, input logic tmo);
        return mk(0, 0, 0, 0, 0, 0, 0, stalled, cyc, tmo);
    endfunction
    function automatic exp_t e_stall(input logic stalled, input int cyc, input logic tmo);
        return mk(1, 1, 0, 0, 0, 0, 1, stalled, cyc, tmo);
    endfunction
    function automatic exp_t e_frz(input logic stalled, input int cyc, input logic tmo);
        return mk(1, 1, 1, 1, 1, 0, 0, stalled, cyc, tmo);
    endfunction

    task automatic apply(input in_t v);
        bus.i_if_id_rs1       = v.rs1;
        bus.i_if_id_rs2       = v.rs2;
        bus.i_if_id_use_rs1   = v.use1;
        bus.i_if_id_use_rs2   = v.use2;
        bus.i_if_id_is_branch = v.isbr;
        bus.i_branch_taken    = v.bt;
        bus.i_id_ex_rd        = v.exrd;
        bus.i_id_ex_mem_read  = v.exld;
        bus.i_ex_mem_rd       = v.memrd;
        bus.i_ex_mem_mem_read = v.memld;
        bus.i_imem_ready      = v.imem;
        bus.i_dmem_req        = v.dreq;
        bus.i_dmem_ready      = v.drdy;
    endtask

    // One vector per clock: applied just after the edge, checked at the falling edge.
    task automatic drive(input in_t v, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        apply(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Asserts reset asynchronously with the given inputs present, expects all-zero outputs.
    task automatic do_reset(input in_t v, input string nm);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        apply(v);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        name_q.push_back(nm);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        apply(nop());
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g.pc      = bus.o_pc_stall;
            g.ifid    = bus.o_if_id_stall;
            g.idex    = bus.o_id_ex_stall;
            g.exmem   = bus.o_ex_mem_stall;
            g.memwb   = bus.o_mem_wb_stall;
            g.ifid_fl = bus.o_if_id_flush;
            g.idex_fl = bus.o_id_ex_flush;
            g.stalled = bus.o_stalled;
            g.cyc     = bus.o_stall_cycles;
            g.tmo     = bus.o_mem_timeout;
            n_chk++;
            if (g === e) n_pass++;
            else $display("FAIL %s: got stl=%b fl=%b stalled=%b cyc=%0d tmo=%b, required stl=%b fl=%b stalled=%b cyc=%0d tmo=%b",
                          nm, {g.pc, g.ifid, g.idex, g.exmem, g.memwb}, {g.ifid_fl, g.idex_fl},
                          g.stalled, g.cyc, g.tmo,
                          {e.pc, e.ifid, e.idex, e.exmem, e.memwb}, {e.ifid_fl, e.idex_fl},
                          e.stalled, e.cyc, e.tmo);
        end
    end

    initial begin
        in_t v;
        in_t hz;
        in_t frz;
        apply(nop());

        // Reset with a live load-use hazard on the inputs.
        hz = nop(); hz.exld = 1; hz.exrd = 5; hz.rs1 = 5; hz.use1 = 1;
        do_reset(hz, "reset_outputs");

        // Load x5 in EX, ADD reads x5: single stall cycle.
        drive(hz, e_stall(0, 0, 0), "ldu_ex_alu_stall");
        v = nop(); v.rs1 = 5; v.use1 = 1;
        drive(v, e_idle(0, 1, 0), "ldu_ex_alu_release");

        // Load x7 in EX, BEQ reads x7 as rs2: two stall cycles.
        do_reset(nop(), "reset_2");
        v = nop(); v.exld = 1; v.exrd = 7; v.rs2 = 7; v.use2 = 1; v.isbr = 1;
        drive(v, e_stall(0, 0, 0), "ldu_br_stall1");
        v.exld = 0; v.exrd = 0; v.memld = 1; v.memrd = 7;
        drive(v, e_stall(1, 1, 0), "ldu_br_stall2");
        drive(nop(), e_idle(0, 2, 0), "ldu_br_run");

        // Cases that must not stall, and a branch consuming a load in MEM.
        do_reset(nop(), "reset_3");
        v = nop(); v.exld = 1; v.exrd = 0; v.rs1 = 0; v.use1 = 1;
        drive(v, e_idle(0, 0, 0), "x0_no_stall");
        v = nop(); v.exld = 1; v.exrd = 5; v.rs1 = 5; v.use1 = 0;
        drive(v, e_idle(0, 0, 0), "unused_rs1_no_stall");
        v = nop(); v.memld = 1; v.memrd = 3; v.rs1 = 3; v.use1 = 1;
        drive(v, e_idle(0, 0, 0), "mem_load_alu_no_stall");
        v.isbr = 1;
        drive(v, e_stall(0, 0, 0), "mem_load_branch_stall");
        drive(nop(), e_idle(0, 1, 0), "mem_load_branch_release");

        // Branch flush, its suppression under a stall, and fetch wait.
        do_reset(nop(), "reset_4");
        v = nop(); v.bt = 1; v.imem = 0;
        drive(v, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "branch_flush_imem_busy");
        v = hz; v.bt = 1; v.imem = 0;
        drive(v, e_stall(0, 0, 0), "branch_during_ldu_ignored");
        v = nop(); v.imem = 0;
        drive(v, mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0), "fetch_wait");
        v = nop(); v.exld = 1; v.exrd = 7; v.rs2 = 7; v.use2 = 1; v.isbr = 1;
        drive(v, e_stall(0, 2, 0), "br_stall1_b");
        v = nop(); v.bt = 1; v.memld = 1; v.memrd = 7; v.rs2 = 7; v.use2 = 1; v.isbr = 1;
        drive(v, e_stall(1, 3, 0), "branch_in_stall_state_ignored");
        drive(nop(), e_idle(0, 4, 0), "branch_case_run");

        // Freeze during the 2nd stall of a branch load-use.
        do_reset(nop(), "reset_5");
        v = nop(); v.exld = 1; v.exrd = 7; v.rs2 = 7; v.use2 = 1; v.isbr = 1;
        drive(v, e_stall(0, 0, 0), "frz_br_stall1");
        frz = nop(); frz.memld = 1; frz.memrd = 7; frz.rs2 = 7; frz.use2 = 1; frz.isbr = 1;
        frz.bt = 1; frz.dreq = 1; frz.drdy = 0;
        for (int i = 0; i < 5; i++)
            drive(frz, e_frz(1, 1 + i, (i == 4)), $sformatf("frz_in_stall_%0d", i));
        frz.dreq = 1; frz.drdy = 1; frz.bt = 0;
        drive(frz, e_stall(1, 6, 1), "frz_remaining_stall");
        drive(nop(), e_idle(0, 7, 1), "frz_back_to_run");

        // Freeze counter clears on a non-freeze cycle.
        do_reset(nop(), "reset_6");
        frz = nop(); frz.dreq = 1;
        for (int i = 0; i < 3; i++)
            drive(frz, e_frz(0, i, 0), $sformatf("frz_a_%0d", i));
        drive(nop(), e_idle(0, 3, 0), "frz_gap");
        drive(frz, e_frz(0, 3, 0), "frz_b_0");
        drive(frz, e_frz(0, 4, 0), "frz_b_1");
        drive(nop(), e_idle(0, 5, 0), "frz_no_timeout");

        // Timeout after 4 freeze cycles, sticky, then cleared by reset mid-freeze.
        do_reset(nop(), "reset_7");
        for (int i = 0; i < 4; i++)
            drive(frz, e_frz(0, i, 0), $sformatf("tmo_frz_%0d", i));
        v = nop(); v.dreq = 1; v.drdy = 1;
        drive(v, e_idle(0, 4, 1), "tmo_set_after_ready");
        drive(nop(), e_idle(0, 4, 1), "tmo_sticky");
        drive(frz, e_frz(0, 4, 1), "tmo_frz_again");
        do_reset(frz, "reset_mid_freeze");
        drive(nop(), e_idle(0, 0, 0), "after_reset_cleared");

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
